// File: rtl/bcd_stopwatch_pkg.sv
// Shared types and constants for the cascaded BCD stopwatch controller.
package bcd_stopwatch_pkg;

  localparam int unsigned BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  typedef logic [1:0] sw_state_t;

  localparam sw_state_t ST_IDLE  = 2'd0;
  localparam sw_state_t ST_RUN   = 2'd1;
  localparam sw_state_t ST_PAUSE = 2'd2;

  // Any value at or above 9 wraps to 0, so 10..15 can never be produced.
  function automatic logic [BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] v);
    if (v >= BCD_MAX) begin
      return '0;
    end
    return v + 4'd1;
  endfunction

endpackage

// File: rtl/bcd_stopwatch_ctrl_digit.sv
// One BCD decade of the stopwatch counter with ripple carry to the next decade.
module bcd_digit
  import bcd_stopwatch_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [BCD_W-1:0] value,
  output logic             carry
);

  logic [BCD_W-1:0] value_q;
  logic [BCD_W-1:0] value_d;

  always_comb begin
    value_d = value_q;
    if (clr) begin
      value_d = '0;
    end else if (inc) begin
      value_d = bcd_inc(value_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;
  assign carry = inc & (value_q == BCD_MAX);

endmodule

// File: rtl/bcd_stopwatch_ctrl.sv
// BCD stopwatch controller: IDLE/RUN/PAUSE FSM, tick prescaler, cascaded BCD digits.
// Optional lap snapshot/handshake enabled by defining BCD_STOPWATCH_LAP_EN.
module bcd_stopwatch_ctrl
  import bcd_stopwatch_pkg::*;
#(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned TICK_DIV = 10
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      stop,
  input  logic                      clear,
  input  logic                      lap_req,
  input  logic                      lap_ready,
  output logic [BCD_W*DIGITS-1:0]   count,
  output logic                      running,
  output logic                      overflow,
  output logic                      lap_valid,
  output logic [BCD_W*DIGITS-1:0]   lap_data
);

  localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);

  sw_state_t   state_q;
  sw_state_t   state_d;
  logic [15:0] presc_q;
  logic [15:0] presc_d;
  logic        overflow_q;
  logic        overflow_d;
  logic        tick;
  logic        tick_eff;

  logic [DIGITS:0]               inc_chain;
  logic [BCD_W*DIGITS-1:0]       count_w;

  assign tick     = (state_q == ST_RUN) && (presc_q == TICK_LAST);
  // A same-edge stop or clear swallows the tick.
  assign tick_eff = tick & ~stop & ~clear;

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_IDLE;
    end else if (stop) begin
      if (state_q == ST_RUN) begin
        state_d = ST_PAUSE;
      end
    end else if (start && (state_q == ST_IDLE || state_q == ST_PAUSE)) begin
      state_d = ST_RUN;
    end
  end

  always_comb begin
    presc_d = presc_q;
    if (clear) begin
      presc_d = '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (stop && tick) begin
            presc_d = presc_q;
          end else if (tick) begin
            presc_d = '0;
          end else begin
            presc_d = presc_q + 16'd1;
          end
        end
        ST_PAUSE: presc_d = presc_q;
        default:  presc_d = '0;
      endcase
    end
  end

  always_comb begin
    overflow_d = overflow_q | inc_chain[DIGITS];
    if (clear) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      presc_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      overflow_q <= overflow_d;
    end
  end

  assign inc_chain[0] = tick_eff;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clear),
      .inc   (inc_chain[g]),
      .value (count_w[BCD_W*g +: BCD_W]),
      .carry (inc_chain[g+1])
    );
  end

  assign count    = count_w;
  assign running  = (state_q == ST_RUN);
  assign overflow = overflow_q;

`ifdef BCD_STOPWATCH_LAP_EN
  logic                    lap_valid_q;
  logic                    lap_valid_d;
  logic [BCD_W*DIGITS-1:0] lap_data_q;
  logic [BCD_W*DIGITS-1:0] lap_data_d;

  // Handshake completion takes precedence, so a same-edge lap_req is dropped.
  always_comb begin
    lap_valid_d = lap_valid_q;
    lap_data_d  = lap_data_q;
    if (clear) begin
      lap_valid_d = 1'b0;
    end else if (lap_valid_q) begin
      if (lap_ready) begin
        lap_valid_d = 1'b0;
      end
    end else if (lap_req && (state_q == ST_RUN || state_q == ST_PAUSE)) begin
      lap_valid_d = 1'b1;
      lap_data_d  = count_w;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lap_valid_q <= 1'b0;
      lap_data_q  <= '0;
    end else begin
      lap_valid_q <= lap_valid_d;
      lap_data_q  <= lap_data_d;
    end
  end

  assign lap_valid = lap_valid_q;
  assign lap_data  = lap_data_q;
`else
  logic lap_unused;

  assign lap_unused = lap_req | lap_ready;
  assign lap_valid  = 1'b0;
  assign lap_data   = '0;
`endif

endmodule
